mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Parametrised byte-serial memory controller for the out-of-order core.
//  Arbitrates NUM_CH requesters (ifetch, LSB, future D-cache refill) onto the single 8-bit RAM/IO bus.
//  Reads/writes of 1..MAX_BYTES little-endian bytes; round-robin fairness; rollback cancels speculative reads.
//  Replaces the fixed two-port (IF + LSB) controller; sits between the requesters and cpu top-level mem_* pins.
// PARAMETERS
//  NUM_CH        2         number of requester channels (>=1); channel 0 = ifetch by convention
//  ADDR_W        32        address width
//  MAX_BYTES     4         max bytes per request; DATA_W = 8*MAX_BYTES; LEN_W = $clog2(MAX_BYTES+1)
//  IO_HI         2'b11     addr[17:16] value that marks the IO region
//  RB_MASK       {NUM_CH{1'b1}} bit c=1: reads on channel c are cancelled by rollback
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset, asynchronous, active-low
//  rdy        in   1                 global ready; low freezes the block
//  rollback   in   1                 mispredict flush
//  mem_din    in   8                 RAM/IO read byte (valid the cycle after its address)
//  mem_dout   out  8                 write byte
//  mem_a      out  ADDR_W            byte address
//  mem_wr     out  1                 1 = write this cycle
//  io_buffer_full in 1               UART buffer full
//  req_en     in   NUM_CH            per-channel request; held until done
//  req_wr     in   NUM_CH            per-channel 1 = write
//  req_addr   in   NUM_CH*ADDR_W     per-channel start address
//  req_len    in   NUM_CH*LEN_W      per-channel byte count, 1..MAX_BYTES
//  req_wdata  in   NUM_CH*DATA_W     per-channel write data, byte 0 = bits [7:0]
//  done       out  NUM_CH            one-cycle completion pulse, one-hot
//  rdata      out  DATA_W            read data, zero-extended, valid with done
//  busy       out  1                 state != IDLE
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, rr pointer 0, mem_a=0, mem_dout=0, mem_wr=0, done=0, rdata=0, busy=0.
//  All outputs registered. States: IDLE, READ, WRITE, DONE.
//  IDLE: grant first req_en channel at or after rr pointer (wrapping); latch addr/len/wdata/wr -> READ/WRITE.
//   Accept cycle = cycle 0; rr pointer <- granted+1 mod NUM_CH.
//  READ, len L: cycles 1..L mem_a = addr+k-1, mem_wr=0; byte k-1 captured from mem_din in cycle k+1;
//   -> DONE; done[ch]=1 and rdata valid in cycle L+2.
//  WRITE, len L: cycles 1..L mem_wr=1, mem_a = addr+k-1, mem_dout = wdata byte k-1; done in cycle L+1.
//  IO stall: write byte with addr[17:16]==IO_HI while io_buffer_full=1 -> mem_wr=0, byte held, index frozen;
//   issue resumes in the first cycle io_buffer_full=0. Reads never stall.
//  DONE: done pulse, mem_wr=0, no grant this cycle; next cycle IDLE.
//   Requesters drop req_en on the edge sampling done.
//  Back-to-back: min gap between dones = L+3 (read) / L+2 (write) cycles.
//  rdy=0: state, counters, capture and outputs frozen, except mem_wr forced 0. done not re-pulsed.
//  rollback=1 (rdy=1): active READ on a channel with RB_MASK=1 aborts.
//   Next cycle IDLE, no done, mem_a=0; captured bytes dropped.
//   WRITE and DONE never aborted (stores already committed).
//   In IDLE, masked channels not granted in the rollback cycle.
//  req_len=0 or >MAX_BYTES: illegal; simulation assertion; RTL treats as 1.
//  Address increment wraps modulo 2^ADDR_W. NUM_CH=1: rr pointer constant 0.
//  req_en deasserted mid-operation (no rollback): operation still completes, done still pulses.
// TESTING
//  1 ch0 read 0x100 len4, RAM 11 22 33 44
//    -> mem_a 0x100..0x103 cycles 1-4; done[0] cycle 6; rdata=0x44332211.
//  2 ch1 write 0x200 len2 wdata 0xBEEF
//    -> mem_wr=1 cycles 1-2, dout EF then BE; done[1] cycle 3; nothing else written.
//  3 ch0, ch1 request together from reset, re-request after each done
//    -> grant order 0,1,0,1; no done overlap.
//  4 write 0x30000 len1 with io_buffer_full high cycles 1-3
//    -> mem_wr=0 cycles 1-3, mem_wr=1 dout byte cycle 4; done cycle 5.
//  5 rollback cycle 2 of ch0 len4 read -> no done[0], IDLE cycle 3, ch1 granted next;
//    rollback during ch1 write -> write completes, done[1] on time.
//  6 rdy=0 cycles 2-3 of len4 read -> done cycle 8, same rdata;
//    rst=0 mid-write -> mem_wr/done/busy 0 immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM/IO bus controller shared by NUM_CH requesters.
// Round-robin grant, little-endian multi-byte reads and writes, IO write stall,
// and rollback cancellation of speculative reads.
module mem_arbiter #(
   parameter int                NUM_CH    = 2,
   parameter int                ADDR_W    = 32,
   parameter int                MAX_BYTES = 4,
   parameter logic [1:0]        IO_HI     = 2'b11,
   parameter logic [NUM_CH-1:0] RB_MASK   = {NUM_CH{1'b1}},
   localparam int               DATA_W    = 8 * MAX_BYTES,
   localparam int               LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     rdy_i,
   input  logic                     rollback_i,
   input  logic [7:0]               mem_din_i,
   output logic [7:0]               mem_dout_o,
   output logic [ADDR_W-1:0]        mem_a_o,
   output logic                     mem_wr_o,
   input  logic                     io_buffer_full_i,
   input  logic [NUM_CH-1:0]        req_en_i,
   input  logic [NUM_CH-1:0]        req_wr_i,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_CH*LEN_W-1:0]  req_len_i,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
   output logic [NUM_CH-1:0]        done_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     busy_o
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

   state_t              state_q;
   logic [CH_W-1:0]     rr_q, ch_q;
   logic [LEN_W-1:0]    len_q, idx_q, rdSlot_q;
   logic                rdSlotVld_q;
   logic [ADDR_W-1:0]   mem_a_q;
   logic [7:0]          mem_dout_q;
   logic                mem_wr_q;
   logic [DATA_W-1:0]   wdata_q, data_q, rdata_q;
   logic [NUM_CH-1:0]   done_q;
   logic                busy_q;

   logic                grantValid;
   logic [CH_W-1:0]     grantCh, candCh, rrNext;
   logic [ADDR_W-1:0]   addrSel;
   logic [LEN_W-1:0]    lenSel, lenEff;
   logic [DATA_W-1:0]   wdataSel, wdataShift, dataCap;
   logic                wrSel, ioStall, byteFire, rdIssue, abort;
   logic [NUM_CH-1:0]   chOneHot;

   // An IO-region write waits while the UART buffer is full; the gate is combinational so
   // the stall and the rdy freeze take effect in the same cycle the condition is seen.
   assign ioStall    = (state_q == ST_WRITE) && (mem_a_q[17:16] == IO_HI) && io_buffer_full_i;
   assign byteFire   = rdy_i && mem_wr_q && !ioStall;
   assign mem_wr_o   = mem_wr_q && rdy_i && !ioStall;
   assign rdIssue    = (state_q == ST_READ) && (idx_q < len_q);
   assign abort      = rdy_i && rollback_i && (state_q == ST_READ) && RB_MASK[ch_q];
   assign wdataShift = wdata_q >> 8;
   assign rrNext     = (grantCh == CH_W'(NUM_CH - 1)) ? '0 : grantCh + CH_W'(1);
   assign lenEff     = (lenSel == '0 || lenSel > LEN_W'(MAX_BYTES)) ? LEN_W'(1) : lenSel;

   assign mem_a_o    = mem_a_q;
   assign mem_dout_o = mem_dout_q;
   assign done_o     = done_q;
   assign rdata_o    = rdata_q;
   assign busy_o     = busy_q;

   // Round-robin search: first requesting channel at or after the pointer, skipping
   // rollback-masked channels while a flush is in progress.
   always_comb begin
      grantValid = 1'b0;
      grantCh    = '0;
      candCh     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         candCh = CH_W'((int'(rr_q) + i) % NUM_CH);
         if (!grantValid && req_en_i[candCh] && !(rollback_i && RB_MASK[candCh])) begin
            grantValid = 1'b1;
            grantCh    = candCh;
         end
      end
   end

   // Pick the granted channel's request fields out of the flattened port buses.
   always_comb begin
      addrSel  = '0;
      lenSel   = '0;
      wdataSel = '0;
      wrSel    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grantCh == CH_W'(c)) begin
            addrSel  = req_addr_i[c*ADDR_W +: ADDR_W];
            lenSel   = req_len_i[c*LEN_W +: LEN_W];
            wdataSel = req_wdata_i[c*DATA_W +: DATA_W];
            wrSel    = req_wr_i[c];
         end
      end
   end

   // Read assembly: merge the byte returning this cycle into its slot of the capture word.
   always_comb begin
      dataCap = data_q;
      if (rdSlotVld_q) begin
         for (int b = 0; b < MAX_BYTES; b++) begin
            if (rdSlot_q == LEN_W'(b)) dataCap[b*8 +: 8] = mem_din_i;
         end
      end
   end

   // Completion pulse vector for the channel that owns the current operation.
   always_comb begin
      chOneHot       = '0;
      chOneHot[ch_q] = 1'b1;
   end

   // Main controller. The read-return tracking runs even while rdy is low, because the RAM
   // keeps answering the held address; this keeps captured bytes correct across a freeze.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         ch_q        <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rdSlot_q    <= '0;
         rdSlotVld_q <= 1'b0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         wdata_q     <= '0;
         data_q      <= '0;
         rdata_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         data_q      <= dataCap;
         rdSlot_q    <= idx_q;
         rdSlotVld_q <= rdIssue && !abort;
         if (rdy_i) begin
            case (state_q)
               ST_IDLE: begin
                  if (grantValid) begin
                     ch_q    <= grantCh;
                     rr_q    <= rrNext;
                     len_q   <= lenEff;
                     idx_q   <= '0;
                     mem_a_q <= addrSel;
                     data_q  <= '0;
                     busy_q  <= 1'b1;
                     if (wrSel) begin
                        state_q    <= ST_WRITE;
                        mem_wr_q   <= 1'b1;
                        mem_dout_q <= wdataSel[7:0];
                        wdata_q    <= wdataSel;
                     end else begin
                        state_q  <= ST_READ;
                        mem_wr_q <= 1'b0;
                     end
                  end
               end
               ST_READ: begin
                  if (abort) begin
                     state_q <= ST_IDLE;
                     mem_a_q <= '0;
                     data_q  <= '0;
                     busy_q  <= 1'b0;
                  end else if (idx_q == len_q) begin
                     state_q <= ST_DONE;
                     done_q  <= chOneHot;
                     rdata_q <= dataCap;
                  end else begin
                     idx_q <= idx_q + LEN_W'(1);
                     if (idx_q + LEN_W'(1) < len_q) mem_a_q <= mem_a_q + ADDR_W'(1);
                  end
               end
               ST_WRITE: begin
                  if (byteFire) begin
                     if (idx_q == len_q - LEN_W'(1)) begin
                        state_q  <= ST_DONE;
                        mem_wr_q <= 1'b0;
                        done_q   <= chOneHot;
                     end else begin
                        idx_q      <= idx_q + LEN_W'(1);
                        mem_a_q    <= mem_a_q + ADDR_W'(1);
                        mem_dout_q <= wdataShift[7:0];
                        wdata_q    <= wdataShift;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  done_q  <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Requesters must present a byte count in 1..MAX_BYTES when granted.
   illegalLen: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ST_IDLE && rdy_i && grantValid) |-> (lenSel != '0 && lenSel <= LEN_W'(MAX_BYTES)));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed sequence with a scoreboard of expected bus writes and
// completions, checked against the byte-serial controller.
module tb_mem_arbiter;

   localparam int NUM_CH = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 3;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     rdy;
   logic                     rollback;
   logic [7:0]               memDin = 8'h00;
   logic [7:0]               memDout;
   logic [ADDR_W-1:0]        memA;
   logic                     memWr;
   logic                     ioFull;
   logic [NUM_CH-1:0]        reqEn;
   logic [NUM_CH-1:0]        reqWr;
   logic [NUM_CH*ADDR_W-1:0] reqAddr;
   logic [NUM_CH*LEN_W-1:0]  reqLen;
   logic [NUM_CH*DATA_W-1:0] reqWdata;
   logic [NUM_CH-1:0]        done;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct { int ch; logic [31:0] data; int cycle; bit isRead; } doneExp_t;
   typedef struct { logic [31:0] addr; logic [7:0] data; int cycle; } wrExp_t;

   doneExp_t doneQ[$];
   wrExp_t   wrQ[$];
   doneExp_t dExp;
   wrExp_t   wExp;

   mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_BYTES(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .rollback_i(rollback),
      .mem_din_i(memDin), .mem_dout_o(memDout), .mem_a_o(memA), .mem_wr_o(memWr),
      .io_buffer_full_i(ioFull), .req_en_i(reqEn), .req_wr_i(reqWr),
      .req_addr_i(reqAddr), .req_len_i(reqLen), .req_wdata_i(reqWdata),
      .done_o(done), .rdata_o(rdata), .busy_o(busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle number: cycle t lasts from posedge t to posedge t+1
   always @(posedge clk) cyc <= cyc + 1;

   // RAM contents: four known bytes at 0x100, a fixed pattern elsewhere
   function automatic logic [7:0] ramByte(input logic [31:0] a);
      logic [1:0] lo;
      lo = a[1:0];
      if (a >= 32'h100 && a <= 32'h103) begin
         case (lo)
            2'd0:    return 8'h11;
            2'd1:    return 8'h22;
            2'd2:    return 8'h33;
            default: return 8'h44;
         endcase
      end
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] expRead(input logic [31:0] addr, input int len);
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < len; i++) d[i*8 +: 8] = ramByte(addr + 32'(i));
      return d;
   endfunction

   // Synchronous RAM: the byte for the address seen in one cycle appears in the next
   always @(posedge clk) memDin <= ramByte(memA);

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int ch, input bit wr, input logic [31:0] addr,
                                input int len, input logic [31:0] wd);
      reqWr[ch]               = wr;
      reqAddr[ch*32 +: 32]    = addr;
      reqLen[ch*3 +: 3]       = 3'(len);
      reqWdata[ch*32 +: 32]   = wd;
      reqEn[ch]               = 1'b1;
   endtask

   task automatic pushRead(input int ch, input logic [31:0] addr, input int len, input int doneCyc);
      doneQ.push_back('{ch: ch, data: expRead(addr, len), cycle: doneCyc, isRead: 1'b1});
   endtask

   task automatic pushWrite(input int ch, input logic [31:0] addr, input int len,
                            input logic [31:0] wd, input int acceptCyc);
      for (int i = 0; i < len; i++)
         wrQ.push_back('{addr: addr + 32'(i), data: wd[i*8 +: 8], cycle: acceptCyc + 1 + i});
      doneQ.push_back('{ch: ch, data: 32'h0, cycle: acceptCyc + len + 1, isRead: 1'b0});
   endtask

   // Wait (bounded) for a completion, then drop that channel's request on the next edge
   task automatic serviceDone(input int budget, output int ch);
      bit seen;
      seen = 1'b0;
      ch   = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done != '0) begin
            seen = 1'b1;
            ch   = done[1] ? 1 : 0;
         end
      end
      checkOutput("done_within_budget", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      if (seen) reqEn[ch] = 1'b0;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      reqEn    = '0;
      rollback = 1'b0;
      ioFull   = 1'b0;
      rdy      = 1'b1;
      tick();
      tick();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_mem_wr", 64'(memWr), 64'd0);
      checkOutput("rst_mem_a", 64'(memA), 64'd0);
      checkOutput("rst_mem_dout", 64'(memDout), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_rdata", 64'(rdata), 64'd0);
      rst_n = 1'b1;
      tick();
   endtask

   // Bus monitor: every write byte and every completion must match the scoreboard head
   always @(negedge clk) begin
      if (memWr) begin
         checkOutput("wr_expected", 64'(wrQ.size() > 0), 64'd1);
         if (wrQ.size() > 0) begin
            wExp = wrQ.pop_front();
            checkOutput("wr_addr", 64'(memA), 64'(wExp.addr));
            checkOutput("wr_data", 64'(memDout), 64'(wExp.data));
            checkOutput("wr_cycle", 64'(cyc), 64'(wExp.cycle));
         end
      end
      if (done != '0) begin
         checkOutput("done_expected", 64'(doneQ.size() > 0), 64'd1);
         if (doneQ.size() > 0) begin
            dExp = doneQ.pop_front();
            checkOutput("done_onehot", 64'(done), 64'd1 << dExp.ch);
            checkOutput("done_cycle", 64'(cyc), 64'(dExp.cycle));
            if (dExp.isRead) checkOutput("rdata", 64'(rdata), 64'(dExp.data));
         end
      end
   end

   // Global time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t0;
      int ch;
      reqWr    = '0;
      reqAddr  = '0;
      reqLen   = '0;
      reqWdata = '0;
      doReset();
      tick();

      // Four-byte read from ch0
      t0 = cyc;
      applyStimulus(0, 1'b0, 32'h100, 4, 32'h0);
      pushRead(0, 32'h100, 4, t0 + 6);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkOutput($sformatf("t1_addr_c%0d", k), 64'(memA), 64'(32'h100 + 32'(k - 1)));
         checkOutput("t1_no_write", 64'(memWr), 64'd0);
         checkOutput("t1_busy", 64'(busy), 64'd1);
      end
      serviceDone(20, ch);
      checkOutput("t1_done_ch", 64'(ch), 64'd0);

      // Two-byte write from ch1
      t0 = cyc;
      applyStimulus(1, 1'b1, 32'h200, 2, 32'h0000BEEF);
      pushWrite(1, 32'h200, 2, 32'h0000BEEF, t0);
      serviceDone(20, ch);
      checkOutput("t2_done_ch", 64'(ch), 64'd1);

      // Both channels from reset, each re-requesting once: grant order 0,1,0,1
      doReset();
      t0 = cyc;
      applyStimulus(0, 1'b0, 32'h10, 1, 32'h0);
      applyStimulus(1, 1'b1, 32'h40, 2, 32'h00001234);
      pushRead(0, 32'h10, 1, t0 + 3);
      pushWrite(1, 32'h40, 2, 32'h00001234, t0 + 4);
      pushRead(0, 32'h10, 1, t0 + 11);
      pushWrite(1, 32'h40, 2, 32'h00001234, t0 + 12);
      for (int n = 0; n < 4; n++) begin
         serviceDone(30, ch);
         checkOutput($sformatf("t3_order_%0d", n), 64'(ch), 64'(n % 2));
         if (n < 2 && ch == 0) applyStimulus(0, 1'b0, 32'h10, 1, 32'h0);
         if (n < 2 && ch == 1) applyStimulus(1, 1'b1, 32'h40, 2, 32'h00001234);
      end

      // IO write held off while the UART buffer is full in cycles 1-3
      t0 = cyc;
      applyStimulus(0, 1'b1, 32'h30000, 1, 32'h0000005A);
      wrQ.push_back('{addr: 32'h30000, data: 8'h5A, cycle: t0 + 4});
      doneQ.push_back('{ch: 0, data: 32'h0, cycle: t0 + 5, isRead: 1'b0});
      tick();
      ioFull = 1'b1;
      #1;
      checkOutput("t4_stall_c1", 64'(memWr), 64'd0);
      checkOutput("t4_addr_c1", 64'(memA), 64'h30000);
      checkOutput("t4_dout_c1", 64'(memDout), 64'h5A);
      tick();
      checkOutput("t4_stall_c2", 64'(memWr), 64'd0);
      tick();
      checkOutput("t4_stall_c3", 64'(memWr), 64'd0);
      tick();
      ioFull = 1'b0;
      serviceDone(20, ch);
      checkOutput("t4_done_ch", 64'(ch), 64'd0);

      // Rollback aborts the ch0 read; rollback during the ch1 write is ignored
      t0 = cyc;
      applyStimulus(0, 1'b0, 32'h100, 4, 32'h0);
      tick();
      applyStimulus(1, 1'b1, 32'h300, 3, 32'h00C0FFEE);
      tick();
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      reqEn[0] = 1'b0;
      checkOutput("t5_idle_busy", 64'(busy), 64'd0);
      checkOutput("t5_idle_addr", 64'(memA), 64'd0);
      checkOutput("t5_no_done", 64'(done), 64'd0);
      pushWrite(1, 32'h300, 3, 32'h00C0FFEE, t0 + 3);
      tick();
      tick();
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      serviceDone(20, ch);
      checkOutput("t5_done_ch", 64'(ch), 64'd1);

      // rdy low in cycles 2-3 of a four-byte read stretches completion by two cycles
      t0 = cyc;
      applyStimulus(0, 1'b0, 32'h100, 4, 32'h0);
      pushRead(0, 32'h100, 4, t0 + 8);
      tick();
      tick();
      rdy = 1'b0;
      tick();
      checkOutput("t6_frozen_addr", 64'(memA), 64'h101);
      tick();
      rdy = 1'b1;
      serviceDone(20, ch);
      checkOutput("t6_done_ch", 64'(ch), 64'd0);

      // Reset in the middle of a write clears the bus outputs at once
      applyStimulus(1, 1'b1, 32'h400, 4, 32'hA1B2C3D4);
      wrQ.push_back('{addr: 32'h400, data: 8'hD4, cycle: cyc + 1});
      tick();
      tick();
      rst_n = 1'b0;
      reqEn = '0;
      #1;
      checkOutput("t6_rst_mem_wr", 64'(memWr), 64'd0);
      checkOutput("t6_rst_done", 64'(done), 64'd0);
      checkOutput("t6_rst_busy", 64'(busy), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checkOutput("t6_after_busy", 64'(busy), 64'd0);

      checkOutput("sb_done_drained", 64'(doneQ.size()), 64'd0);
      checkOutput("sb_wr_drained", 64'(wrQ.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
